buffer_unloader: RTL and testbench

Consumer-side counterpart to the datapath's 16-word pipeline buffer stage. It captures a full 16×32-bit frame in one load handshake and then drains it one word per transfer over a valid/ready stream, so downstream single-port logic (register-file writeback, memory store port, debug/trace) can consume a wide pipeline stage serially. It sits directly after the parallel buffer stage and feeds any 32-bit streaming sink.

---
 rtl/buffer_pkg.sv | 13 +
 rtl/buffer_word_bank.sv | 26 ++
 rtl/buffer_unloader.sv | 70 +++++++
 tb/tb_buffer_unloader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared constants and state type for the buffer unloader
package buffer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int IDX_W     = $clog2(DEF_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/buffer_word_bank.sv
// rtl/buffer_word_bank.sv - DEPTH x WIDTH shadow register bank, parallel write, indexed read
module buffer_word_bank import buffer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DEPTH*WIDTH-1:0]     wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= wr_data[i*WIDTH +: WIDTH];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/buffer_unloader.sv
// rtl/buffer_unloader.sv - captures a full frame in one handshake and drains it one word per transfer
module buffer_unloader import buffer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [DEPTH*WIDTH-1:0]     load_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0]   out_index,
  output logic                       out_last,
  output logic                       busy
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);
  localparam logic [IDX_BITS-1:0] ONE      = IDX_BITS'(1);

  state_t              state;
  logic [IDX_BITS-1:0] index;
  logic                xfer;
  logic                load_accept;

  assign out_valid   = (state == SEND);
  assign busy        = out_valid;
  assign out_index   = index;
  assign out_last    = out_valid && (index == LAST_IDX);
  assign xfer        = out_valid && out_ready;
  // Ready on the last transfer lets the next frame follow with no bubble.
  assign load_ready  = !flush && (!out_valid || (xfer && out_last));
  assign load_accept = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
    end else if (flush) begin
      state <= IDLE;
      index <= '0;
    end else if (load_accept) begin
      state <= SEND;
      index <= '0;
    end else if (xfer) begin
      if (out_last) begin
        state <= IDLE;
        index <= '0;
      end else begin
        index <= index + ONE;
      end
    end
  end

  buffer_word_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_accept),
    .wr_data (load_data),
    .rd_idx  (index),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_buffer_unloader.sv
// tb/tb_buffer_unloader.sv - randomized and directed bench for buffer_unloader against a frame-level model
module tb_buffer_unloader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int DW    = WIDTH * DEPTH;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     load_valid;
  logic                     load_ready;
  logic [DW-1:0]            load_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH)-1:0] out_index;
  logic                     out_last;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_frame [DEPTH];
  bit               m_busy;
  int               m_pos;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  buffer_unloader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] seq_frame(input logic [31:0] base);
    logic [DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = base + 32'(i);
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = $urandom;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_frame[i] = '0;
    m_busy = 0;
    m_pos  = 0;
    exp_q.delete();
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_out_valid"},  64'(out_valid),  64'd0);
    chk({pfx, "_out_data"},   64'(out_data),   64'd0);
    chk({pfx, "_out_index"},  64'(out_index),  64'd0);
    chk({pfx, "_out_last"},   64'(out_last),   64'd0);
    chk({pfx, "_busy"},       64'(busy),       64'd0);
    chk({pfx, "_load_ready"}, 64'(load_ready), 64'd1);
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic lv, input logic [DW-1:0] ld, input logic ordy, input logic fl);
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] want;
    bit               rdy_m;
    load_valid = lv;
    load_data  = ld;
    out_ready  = ordy;
    flush      = fl;
    #2;
    rdy_m = !fl && (!m_busy || (ordy && m_pos == DEPTH - 1));
    chk("out_valid",  64'(out_valid),  64'(m_busy));
    chk("out_data",   64'(out_data),   64'(m_frame[m_pos]));
    chk("out_index",  64'(out_index),  64'(m_pos));
    chk("out_last",   64'(out_last),   64'(m_busy && m_pos == DEPTH - 1));
    chk("busy",       64'(busy),       64'(m_busy));
    chk("load_ready", 64'(load_ready), 64'(rdy_m));
    seen = out_data;
    @(posedge clk);
    if (fl) begin
      m_busy = 0;
      m_pos  = 0;
      exp_q.delete();
    end else begin
      if (m_busy && ordy) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          want = exp_q.pop_front();
          chk("sb_word", 64'(seen), 64'(want));
        end
        if (m_pos == DEPTH - 1) begin
          m_busy = 0;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
      if (lv && rdy_m) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_frame[i] = ld[i*WIDTH +: WIDTH];
          exp_q.push_back(ld[i*WIDTH +: WIDTH]);
        end
        m_busy = 1;
        m_pos  = 0;
      end
    end
    #1;
  endtask

  initial begin
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    int            k;

    fa = seq_frame(32'hA000_0000);
    fb = seq_frame(32'hB000_0000);
    rst_n = 1'b0; flush = 1'b0; load_valid = 1'b0; out_ready = 1'b0; load_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    rst_n = 1'b1;

    // Straight drain with out_ready high.
    step(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Stalls with out_ready pattern 1,0,0,1,...
    step(1'b1, fa, 1'b1, 1'b0);
    k = 0;
    while (m_busy && k < 100) begin
      step(1'b0, '0, (k % 3) == 0, 1'b0);
      k++;
    end
    chk("stall_drained", 64'(m_busy), 64'd0);

    // Back-to-back frames via last-word reload.
    step(1'b1, fa, 1'b1, 1'b0);
    k = 0;
    while (m_pos != DEPTH - 1 && k < 40) begin
      step(1'b1, fb, 1'b1, 1'b0);
      k++;
    end
    step(1'b1, fb, 1'b1, 1'b0);
    chk("b2b_reload_busy", 64'(busy), 64'd1);
    chk("b2b_reload_word", 64'(out_data), 64'hB000_0000);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush at index 5 with out_ready high.
    step(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_at_idx", 64'(out_index), 64'd5);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, fb, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges mid-frame.
    step(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    load_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("arst");
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b1, 1'b0);

    // load_data wiggles every cycle after the accepting edge.
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, rand_frame(), ($urandom % 2) == 0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 2) == 0, rand_frame(), ($urandom % 4) != 0, ($urandom % 20) == 0);

    k = 0;
    while (m_busy && k < 40) begin
      step(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    chk("final_idle", 64'(out_valid), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
